// File: rtl/int_controller.sv
// rtl/int_controller.sv - edge-triggered, masked, fixed-priority interrupt controller with EOI handshake
module int_controller #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_i,
  output logic               INT,
  input  logic               INT_ACK,
  input  logic               we,
  input  logic [1:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               in_service,
  output logic [ID_W-1:0]    vec_id
);

  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_VECTOR  = 2'd2;
  localparam logic [1:0] ADDR_EOI     = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACKED   = 2'd2,
    SERVICE = 2'd3
  } state_t;

  state_t             state;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] irq_prev;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] ack_clr;
  logic [ID_W-1:0]    winner;
  logic               mask_wr;
  logic               eoi_wr;
  logic               ack_take;
  logic               unused_wdata;

  assign rise     = irq_i & ~irq_prev;
  assign eligible = pending & ~mask;
  assign mask_wr  = we && (addr == ADDR_MASK);
  assign eoi_wr   = we && (addr == ADDR_EOI);
  assign w1c      = (we && (addr == ADDR_PENDING)) ? wdata[NUM_SRC-1:0] : '0;
  assign ack_take = (state == REQ) && INT_ACK;
  assign ack_clr  = ack_take ? (NUM_SRC'(1) << vec_id) : '0;
  assign unused_wdata = &{1'b0, wdata};

  // Scan from the top down so the lowest eligible index is the last one assigned.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_MASK:    rdata = 32'(mask);
      ADDR_PENDING: rdata = 32'(pending);
      ADDR_VECTOR: begin
        rdata[31]       = in_service;
        rdata[ID_W-1:0] = vec_id;
      end
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      INT        <= 1'b0;
      in_service <= 1'b0;
      vec_id     <= '0;
      mask       <= '0;
      pending    <= '0;
      irq_prev   <= '0;
    end else begin
      irq_prev <= irq_i;
      if (mask_wr) mask <= wdata[NUM_SRC-1:0];
      // A new edge outranks any clear landing on the same bit in this cycle.
      pending <= (pending & ~(w1c | ack_clr)) | rise;

      case (state)
        IDLE: begin
          if (|eligible) begin
            vec_id <= winner;
            state  <= REQ;
            INT    <= 1'b1;
          end
        end
        REQ: begin
          if (INT_ACK) begin
            in_service <= 1'b1;
            state      <= ACKED;
            INT        <= 1'b0;
          end else if (!eligible[vec_id]) begin
            state <= IDLE;
            INT   <= 1'b0;
          end
        end
        ACKED: begin
          if (!INT_ACK) state <= SERVICE;
        end
        SERVICE: begin
          if (eoi_wr) begin
            in_service <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          INT   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// tb/tb_int_controller.sv - randomized bench for int_controller against a behavioural model
module tb_int_controller;

  localparam int NUM_SRC = 8;
  localparam int ID_W    = 3;

  localparam int PH_IDLE    = 0;
  localparam int PH_WAIT    = 1;
  localparam int PH_ACKED   = 2;
  localparam int PH_SERVICE = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [NUM_SRC-1:0] irq_i = '0;
  logic               INT;
  logic               INT_ACK = 1'b0;
  logic               we = 1'b0;
  logic [1:0]         addr = '0;
  logic [31:0]        wdata = '0;
  logic [31:0]        rdata;
  logic               in_service;
  logic [ID_W-1:0]    vec_id;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] cur_irq = '0;

  int         m_phase;
  logic [7:0] m_pend;
  logic [7:0] m_mask;
  logic [7:0] m_prev;
  int         m_vec;
  bit         m_insvc;

  int_controller #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_i      (irq_i),
    .INT        (INT),
    .INT_ACK    (INT_ACK),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .in_service (in_service),
    .vec_id     (vec_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int lowest_set(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] model_read(input int a);
    case (a)
      0:       return {24'h0, m_mask};
      1:       return {24'h0, m_pend};
      2:       return (m_insvc ? 32'h8000_0000 : 32'h0) | 32'(m_vec);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_pend  = '0;
    m_mask  = '0;
    m_prev  = '0;
    m_vec   = 0;
    m_insvc = 0;
  endtask

  task automatic model_step(input logic [7:0] irq, input bit ack, input bit w,
                            input int a, input logic [31:0] d);
    logic [7:0] elig;
    logic [7:0] clr;
    elig = m_pend & ~m_mask;
    clr  = (w && a == 1) ? d[7:0] : 8'h0;
    case (m_phase)
      PH_IDLE:
        if (elig != 0) begin
          m_vec   = lowest_set(elig);
          m_phase = PH_WAIT;
        end
      PH_WAIT:
        if (ack) begin
          clr[m_vec] = 1'b1;
          m_insvc    = 1;
          m_phase    = PH_ACKED;
        end else if (!elig[m_vec]) begin
          m_phase = PH_IDLE;
        end
      PH_ACKED:
        if (!ack) m_phase = PH_SERVICE;
      default:
        if (w && a == 3) begin
          m_insvc = 0;
          m_phase = PH_IDLE;
        end
    endcase
    m_pend = (m_pend & ~clr) | (irq & ~m_prev);
    if (w && a == 0) m_mask = d[7:0];
    m_prev = irq;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".int"}, 32'(INT), 32'(m_phase == PH_WAIT));
    check({tag, ".in_service"}, 32'(in_service), 32'(m_insvc));
    check({tag, ".vec_id"}, 32'(vec_id), 32'(m_vec));
    we = 1'b0;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      check($sformatf("%s.rdata%0d", tag, a), rdata, model_read(a));
    end
  endtask

  task automatic cycle(input string tag, input bit ack, input bit w, input int a,
                       input logic [31:0] d);
    irq_i   = cur_irq;
    INT_ACK = ack;
    we      = w;
    addr    = 2'(a);
    wdata   = d;
    model_step(cur_irq, ack, w, a, d);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input bit ack);
    cycle(tag, ack, 1'b0, 0, 32'h0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // Single source handshake
    cur_irq = 8'h04;
    idle("t1.edge", 0);
    idle("t1.req", 0);
    check("t1.int_hi", 32'(INT), 32'd1);
    check("t1.vec2", 32'(vec_id), 32'd2);
    idle("t1.ack", 1);
    check("t1.int_lo", 32'(INT), 32'd0);
    addr = 2'd2; #1;
    check("t1.vector", rdata, 32'h8000_0002);
    idle("t1.rel", 0);
    cycle("t1.eoi", 0, 1, 3, 32'h0);
    check("t1.svc_lo", 32'(in_service), 32'd0);

    // Two simultaneous edges serviced in priority order
    cur_irq = 8'h26;
    idle("t2.edge", 0);
    idle("t2.req1", 0);
    check("t2.vec1", 32'(vec_id), 32'd1);
    idle("t2.ack1", 1);
    idle("t2.rel1", 0);
    cycle("t2.eoi1", 0, 1, 3, 32'h0);
    idle("t2.req5", 0);
    check("t2.vec5", 32'(vec_id), 32'd5);
    idle("t2.ack5", 1);
    idle("t2.rel5", 0);
    cycle("t2.eoi5", 0, 1, 3, 32'h0);

    // Masked source stays pending until unmasked
    cycle("t3.mask", 0, 1, 0, 32'h08);
    cur_irq = 8'h2E;
    idle("t3.edge", 0);
    idle("t3.held", 0);
    check("t3.int_lo", 32'(INT), 32'd0);
    cycle("t3.unmask", 0, 1, 0, 32'h0);
    idle("t3.req", 0);
    check("t3.vec3", 32'(vec_id), 32'd3);
    idle("t3.ack", 1);
    idle("t3.rel", 0);
    cycle("t3.eoi", 0, 1, 3, 32'h0);

    // Software withdraw, then withdraw racing an ack
    cur_irq = 8'h3E;
    idle("t4.edge", 0);
    idle("t4.req", 0);
    cycle("t4.w1c", 0, 1, 1, 32'h10);
    idle("t4.drop", 0);
    check("t4.int_lo", 32'(INT), 32'd0);
    cur_irq = 8'h2E;
    idle("t4.fall", 0);
    cur_irq = 8'h3E;
    idle("t4.edge2", 0);
    idle("t4.req2", 0);
    cycle("t4.race", 1, 1, 1, 32'h10);
    check("t4.svc_hi", 32'(in_service), 32'd1);
    idle("t4.rel", 0);
    cycle("t4.eoi", 0, 1, 3, 32'h0);

    // New edge during service waits for EOI; EOI in request state is ignored
    cycle("t5.mask", 0, 1, 0, 32'h80);
    cur_irq = 8'h3F;
    idle("t5.edge", 0);
    idle("t5.req", 0);
    cycle("t5.early_eoi", 0, 1, 3, 32'h0);
    check("t5.still_req", 32'(INT), 32'd1);
    idle("t5.ack", 1);
    idle("t5.rel", 0);
    cur_irq = 8'h7F;
    idle("t5.edge6", 0);
    idle("t5.wait6", 0);
    check("t5.int_lo", 32'(INT), 32'd0);
    cycle("t5.eoi", 0, 1, 3, 32'h0);
    idle("t5.req6", 0);
    check("t5.vec6", 32'(vec_id), 32'd6);
    idle("t5.ack6", 1);

    // Asynchronous reset mid-handshake with ack still held
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("t6.int", 32'(INT), 32'd0);
    check("t6.svc", 32'(in_service), 32'd0);
    addr = 2'd1; #1;
    check("t6.pending", rdata, 32'h0);
    addr = 2'd0; #1;
    check("t6.mask", rdata, 32'h0);
    cur_irq = '0;
    irq_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) idle("t6.stale_ack", 1);
    check("t6.no_int", 32'(INT), 32'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      bit          ack;
      bit          w;
      int          a;
      logic [31:0] d;
      if ($urandom_range(0, 2) == 0) cur_irq = cur_irq ^ (8'h01 << $urandom_range(0, 7));
      ack = ($urandom_range(0, 3) == 0);
      w   = ($urandom_range(0, 4) == 0);
      a   = $urandom_range(0, 3);
      d   = (a == 0) ? ($urandom & $urandom & $urandom) : $urandom;
      cycle("rand", ack, w, a, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/int_controller.md
Name: int_controller

Overview:
- Peripheral-side interrupt controller. Drives the CPU's INT request line and consumes the CPU's INT_ACK, forming the source end of the CPU interrupt handshake.
- Collects NUM_SRC edge-triggered device requests, applies a mask and fixed priority, and raises INT.
- Holds the winning source ID as a vector for the handler.
- Blocks further requests until software writes end-of-interrupt (EOI) over a small register port.

Parameters:
- NUM_SRC, 8: number of interrupt sources (1..2**ID_W).
- ID_W, 3: width of the source ID / vector field.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset. Low clears all state immediately.
- irq_i  input  NUM_SRC  device request levels; rising edge = request (same clock domain).
- INT  output  1  interrupt request to CPU; registered.
- INT_ACK  input  1  CPU acknowledge; level, held until the CPU deasserts it.
- we  input  1  register write strobe.
- addr  input  2  register select.
- wdata  input  32  write data.
- rdata  output  32  read data; combinational from addr.
- in_service  output  1  high from acknowledge until EOI.
- vec_id  output  ID_W  ID of the source being requested/serviced.

Behaviour:
- Reset values: INT=0, in_service=0, vec_id=0, PENDING=0, MASK=0 (all enabled), irq_prev=0, state=IDLE.
- Edge detect: a rising edge is irq_i[i]=1 with irq_prev[i]=0 at a posedge. It sets PENDING[i] at that edge, whether or not the source is masked.
- Register map:
  - addr 0 MASK: rw; bit=1 masks the source.
  - addr 1 PENDING: read; write-1-to-clear.
  - addr 2 VECTOR: read-only; {in_service at bit 31, zeros, vec_id in [ID_W-1:0]}.
  - addr 3 EOI: write only (any value); reads 0.
  - Unused high bits of MASK/PENDING read 0.
- Simultaneous set and W1C on the same PENDING bit: set wins.
- eligible = PENDING & ~MASK. Winner = lowest-index eligible bit.
- FSM:
  - IDLE: if eligible != 0, latch winner into vec_id and go REQ. Otherwise stay.
  - REQ: INT=1.
    - If INT_ACK=1: clear PENDING[vec_id], set in_service=1, go ACKED.
    - Else if eligible[vec_id]=0 (masked or cleared by software): go IDLE, INT drops. The next winner is chosen from IDLE.
    - If INT_ACK and the withdraw condition occur in the same cycle, the ack wins.
    - vec_id does not change while in REQ, even if a higher-priority source becomes eligible.
  - ACKED: INT=0. Wait for INT_ACK=0, then go SERVICE.
  - SERVICE: a write to EOI sets in_service=0 and goes IDLE. EOI writes in any other state are ignored.
- INT is a registered decode of state==REQ.
- Latency: rising edge sampled at edge k -> PENDING set after edge k -> INT high after edge k+1.
  - INT_ACK sampled high at edge m -> INT low after edge m.
- New edges keep accumulating in PENDING during REQ/ACKED/SERVICE and are serviced in priority order after EOI.
- A source that re-edges while still pending stays a single pending request; no counting.
- reset low at any time, mid-handshake included: INT falls at once and all state returns to reset values. Stale INT_ACK after reset is ignored in IDLE.

Test Plan:
1. Reset low then high; irq_i[2] rises at edge k -> INT=1 after edge k+1, vec_id=2, PENDING=0x04. Hold INT_ACK=1 -> INT=0 next cycle, PENDING=0x00, VECTOR read=0x80000002. Drop INT_ACK, write EOI -> in_service=0, INT stays 0.
2. irq_i[5] and irq_i[1] rise in the same cycle -> vec_id=1 first. After ack and EOI -> INT reasserts with vec_id=5. Final PENDING=0.
3. MASK=0x08, irq_i[3] rises -> PENDING=0x08, INT stays 0. Write MASK=0 -> INT=1 two edges later, vec_id=3.
4. INT asserted for source 4, no ack. Write PENDING W1C 0x10 -> INT=0 next cycle, state IDLE. Repeat with INT_ACK=1 in the same cycle as the W1C -> ack wins, in_service=1.
5. During SERVICE of source 0, irq_i[6] rises -> INT stays 0 until EOI, then INT=1 with vec_id=6. An EOI written in REQ has no effect.
6. Pull reset low while in ACKED with INT_ACK=1 -> INT=0, in_service=0, PENDING=0, MASK=0 immediately. Release reset with INT_ACK still 1 -> no INT until a new edge.
